cordic_arbiter: RTL and testbench
=================================

# cordic_arbiter

Round-robin arbiter and sequencer that shares one sequential 16-bit CORDIC rotator among NREQ independent requesters. It sits between the DPLL/NCO-side clients and the CORDIC. It accepts one rotation request at a time, launches it on the CORDIC, and waits for completion. It then returns the rotated (x, y) pair to the granted requester as a one-cycle, one-hot response.

## Interface
- NREQ, 4, number of requesters (2..8)
- IDW, $clog2(NREQ), requester index width
- TIMEOUT, 32, cycles allowed in WAIT before abort (used only with CORDIC_ARB_TIMEOUT_EN)
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_req_valid  in  NREQ  per-requester request valid
- o_req_ready  out  NREQ  per-requester accept; at most one bit set
- i_req_x  in  16*NREQ  signed x, requester k at [16k+15:16k]
- i_req_y  in  16*NREQ  signed y, same packing
- i_req_phase  in  32*NREQ  phase, 2^32 = 360°, requester k at [32k+31:32k]
- o_rsp_valid  out  NREQ  one-hot, one-cycle response strobe
- o_rsp_x, o_rsp_y  out  16 each  rotated result, valid with o_rsp_valid
- o_rsp_err  out  1  response aborted by timeout
- o_rsp_id  out  IDW  index of the responding requester
- o_c_reset  out  1  CORDIC reset
- o_c_stb  out  1  CORDIC start strobe
- o_c_x, o_c_y  out  16 each  CORDIC operands
- o_c_phase  out  32  CORDIC phase operand
- i_c_busy  in  1  CORDIC busy
- i_c_done  in  1  CORDIC result strobe
- i_c_x, i_c_y  in  16 each  CORDIC results

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - Round-robin pick among the set i_req_valid bits, searching upward from pointer rr (wrapping at NREQ).
  - o_req_ready is combinational: only the winner's bit is set, and only in IDLE.
  - When a handshake occurs, register x/y/phase and the grant index g, set rr ← (g+1) mod NREQ, and go to ISSUE.
  - With no valid request, stay in IDLE; rr holds.
- **ISSUE**
  - If !i_c_busy: assert o_c_stb for exactly one cycle and go to WAIT.
  - Otherwise hold in ISSUE with o_c_stb=0.
- **WAIT**
  - On i_c_done: latch i_c_x/i_c_y and go to RESP.
  - Any i_c_done seen outside WAIT is ignored.
- **RESP**
  - For one cycle: o_rsp_valid[g]=1, o_rsp_id=g, results driven.
  - Then return to IDLE. No backpressure; requesters must take the response.
- o_c_x/o_c_y/o_c_phase are driven from the operand registers and are stable from ISSUE through WAIT.
- o_rsp_x/o_rsp_y hold their value after RESP until the next RESP.
- o_c_reset = i_reset, OR'd with the abort pulse when CORDIC_ARB_TIMEOUT_EN is defined.
- Requests arriving while not in IDLE simply wait; valid must be held until ready.

## Timing
- Values after reset:
  - State = IDLE, rr = 0.
  - o_req_ready=0, o_rsp_valid=0, o_c_stb=0, o_rsp_err=0.
  - o_rsp_x=0, o_rsp_y=0, o_rsp_id=0, operand registers=0.
- Handshake cycle t (IDLE) → o_c_stb at t+1 (if not busy) → i_c_done at t+1+L, where L is the CORDIC latency (about 20) → o_rsp_valid at t+2+L → next handshake possible at t+3+L.
- i_c_done and o_c_stb never overlap.
- Reset mid-operation (any state) aborts the operation and produces no response. Because o_c_reset = i_reset, the CORDIC is reset in the same cycle.
- Simultaneous requests: exactly one is granted per IDLE visit. With all bits held high, grants run 0,1,…,NREQ-1,0,…

## Configuration
- Macro: CORDIC_ARB_TIMEOUT_EN.
- **Defined:**
  - A counter runs in WAIT, starting at 0 on entry.
  - When the counter reaches TIMEOUT-1 without i_c_done:
    - o_c_reset pulses for one cycle;
    - the FSM enters RESP with o_rsp_err=1 and o_rsp_x = o_rsp_y = 0.
  - o_rsp_err is 0 on normal responses.
- **Undefined:**
  - No counter is built; WAIT waits indefinitely.
  - o_rsp_err is tied to 0 and o_c_reset = i_reset.

## Test plan
- Single request, real CORDIC:
  - Stimulus: req 2 with x=16'h4000, y=0, phase=32'h40000000.
  - Response: one o_rsp_valid=4'b0100 pulse, o_rsp_id=2, o_rsp_x=0±2, o_rsp_y=16'h4A86±2 (gain 1.1644), o_rsp_err=0.
- All four requesters held valid for 8 operations:
  - Grant order 0,1,2,3,0,1,2,3.
  - Exactly one o_req_ready bit high per handshake.
  - Each response's id matches its grant.
- Stub CORDIC holds i_c_busy=1 for 5 cycles after the handshake:
  - o_c_stb stays 0 for 5 cycles, then is asserted for exactly one cycle.
- Assert i_reset for 1 cycle at WAIT cycle 10:
  - No o_rsp_valid is produced; o_c_reset=1 in that cycle; FSM is in IDLE with rr=0.
  - A new request on requester 1 then completes normally.
- Stray i_c_done pulse while in IDLE:
  - No response is produced; state is unchanged.
- With CORDIC_ARB_TIMEOUT_EN and TIMEOUT=32, stub never asserts i_c_done:
  - o_c_reset pulses 32 cycles after WAIT entry.
  - o_rsp_valid fires the next cycle with o_rsp_err=1 and zero data.

Source files
------------

// File: rtl/cordic_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cordic_arbiter_if                                                |
// | Requester-side and CORDIC-side buses of the CORDIC arbiter.      |
// | slave  : arbiter view.                                           |
// | master : environment view (requesters and CORDIC).               |
// | Revision: 1.0  initial release                                   |
// +------------------------------------------------------------------+
interface cordic_arbiter_if #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
);
   // requester side
   logic [NREQ-1:0]    i_req_valid;
   logic [NREQ-1:0]    o_req_ready;
   logic [16*NREQ-1:0] i_req_x;
   logic [16*NREQ-1:0] i_req_y;
   logic [32*NREQ-1:0] i_req_phase;
   logic [NREQ-1:0]    o_rsp_valid;
   logic [15:0]        o_rsp_x;
   logic [15:0]        o_rsp_y;
   logic               o_rsp_err;
   logic [IDW-1:0]     o_rsp_id;
   // CORDIC side
   logic               o_c_reset;
   logic               o_c_stb;
   logic [15:0]        o_c_x;
   logic [15:0]        o_c_y;
   logic [31:0]        o_c_phase;
   logic               i_c_busy;
   logic               i_c_done;
   logic [15:0]        i_c_x;
   logic [15:0]        i_c_y;

   modport slave (
      input  i_req_valid, i_req_x, i_req_y, i_req_phase,
      input  i_c_busy, i_c_done, i_c_x, i_c_y,
      output o_req_ready, o_rsp_valid, o_rsp_x, o_rsp_y, o_rsp_err, o_rsp_id,
      output o_c_reset, o_c_stb, o_c_x, o_c_y, o_c_phase
   );

   modport master (
      output i_req_valid, i_req_x, i_req_y, i_req_phase,
      output i_c_busy, i_c_done, i_c_x, i_c_y,
      input  o_req_ready, o_rsp_valid, o_rsp_x, o_rsp_y, o_rsp_err, o_rsp_id,
      input  o_c_reset, o_c_stb, o_c_x, o_c_y, o_c_phase
   );
endinterface
`default_nettype wire

// File: rtl/cordic_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cordic_arbiter                                                   |
// | Round-robin arbiter/sequencer sharing one sequential CORDIC      |
// | rotator among NREQ requesters. One request in flight at a time.  |
// | Optional macro CORDIC_ARB_TIMEOUT_EN: abort WAIT after TIMEOUT   |
// | cycles, reset the CORDIC and answer with an error response.      |
// | Revision: 1.0  initial release                                   |
// +------------------------------------------------------------------+
module cordic_arbiter #(
   parameter int NREQ    = 4,
   parameter int IDW     = $clog2(NREQ),
   parameter int TIMEOUT = 32
) (
   input  logic            i_clk,
   input  logic            i_reset,
   cordic_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic [IDW-1:0] rr;
   logic [IDW-1:0] grant;
   logic [IDW-1:0] win;
   logic [IDW-1:0] win_inc;
   logic [IDW:0]   sum;
   logic [IDW-1:0] idx;
   logic           found;
   logic           handshake;
   logic           abort;
   logic [15:0]    op_x;
   logic [15:0]    op_y;
   logic [31:0]    op_phase;
   logic [15:0]    rsp_x;
   logic [15:0]    rsp_y;

   // Round-robin search: first valid requester at or above rr, wrapping at NREQ
   always_comb begin
      found = 1'b0;
      win   = rr;
      sum   = '0;
      idx   = '0;
      for (int i = 0; i < NREQ; i++) begin
         sum = {1'b0, rr} + (IDW+1)'(i);
         if (sum >= (IDW+1)'(NREQ)) begin
            sum = sum - (IDW+1)'(NREQ);
         end
         idx = sum[IDW-1:0];
         if (!found && bus.i_req_valid[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   assign handshake = (state == IDLE) && found;
   assign win_inc   = (win == IDW'(NREQ-1)) ? '0 : win + IDW'(1);

`ifdef CORDIC_ARB_TIMEOUT_EN
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [CW-1:0] wait_cnt;
   logic          err;

   // WAIT-cycle counter, cleared whenever the FSM is not waiting
   always_ff @(posedge i_clk) begin
      if (i_reset || state != WAIT) begin
         wait_cnt <= '0;
      end else begin
         wait_cnt <= wait_cnt + CW'(1);
      end
   end

   // Error flag captured on the WAIT->RESP transition
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         err <= 1'b0;
      end else if (state == WAIT) begin
         err <= abort;
      end
   end

   // A result arriving on the last allowed cycle wins over the abort
   assign abort         = (state == WAIT) && !bus.i_c_done && (wait_cnt == CW'(TIMEOUT-1));
   assign bus.o_rsp_err = (state == RESP) && err;
   assign bus.o_c_reset = i_reset | abort;
`else
   assign abort         = 1'b0;
   assign bus.o_rsp_err = 1'b0;
   assign bus.o_c_reset = i_reset;
`endif

   // FSM state register
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state and strobes
   always_comb begin
      state_nxt       = state;
      bus.o_req_ready = '0;
      bus.o_rsp_valid = '0;
      bus.o_c_stb     = 1'b0;
      case (state)
         IDLE: begin
            if (handshake) begin
               bus.o_req_ready = NREQ'(1) << win;
               state_nxt       = ISSUE;
            end
         end
         ISSUE: begin
            if (!bus.i_c_busy) begin
               bus.o_c_stb = 1'b1;
               state_nxt   = WAIT;
            end
         end
         WAIT: begin
            if (bus.i_c_done || abort) begin
               state_nxt = RESP;
            end
         end
         RESP: begin
            bus.o_rsp_valid = NREQ'(1) << grant;
            state_nxt       = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Grant/pointer, operand capture on handshake, result capture in WAIT
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         rr       <= '0;
         grant    <= '0;
         op_x     <= '0;
         op_y     <= '0;
         op_phase <= '0;
         rsp_x    <= '0;
         rsp_y    <= '0;
      end else begin
         if (handshake) begin
            grant    <= win;
            rr       <= win_inc;
            op_x     <= bus.i_req_x[{win, 4'b0000} +: 16];
            op_y     <= bus.i_req_y[{win, 4'b0000} +: 16];
            op_phase <= bus.i_req_phase[{win, 5'b00000} +: 32];
         end
         if (state == WAIT) begin
            if (bus.i_c_done) begin
               rsp_x <= bus.i_c_x;
               rsp_y <= bus.i_c_y;
            end else if (abort) begin
               rsp_x <= '0;
               rsp_y <= '0;
            end
         end
      end
   end

   assign bus.o_c_x     = op_x;
   assign bus.o_c_y     = op_y;
   assign bus.o_c_phase = op_phase;
   assign bus.o_rsp_x   = rsp_x;
   assign bus.o_rsp_y   = rsp_y;
   assign bus.o_rsp_id  = grant;

endmodule
`default_nettype wire

// File: tb/tb_cordic_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_cordic_arbiter                                                |
// | Directed bench for cordic_arbiter with a stub CORDIC of fixed    |
// | latency L whose result is operand XOR (kx, ky).                  |
// | Timeout scenario built only with CORDIC_ARB_TIMEOUT_EN.          |
// | Revision: 1.0  initial release                                   |
// +------------------------------------------------------------------+
module tb_cordic_arbiter;
   localparam int NREQ = 4;
   localparam int L    = 20;

   logic clk     = 1'b0;
   logic i_reset = 1'b1;

   cordic_arbiter_if #(.NREQ(NREQ)) bus ();

   cordic_arbiter #(.NREQ(NREQ), .TIMEOUT(32)) dut (
      .i_clk   (clk),
      .i_reset (i_reset),
      .bus     (bus)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   int          rsp_cnt = 0;
   logic        stub_act = 1'b0;
   logic        stub_done = 1'b0;
   logic        stray_done = 1'b0;
   logic        ext_busy = 1'b0;
   logic        stub_never = 1'b0;
   int          stub_cnt = 0;
   logic [15:0] kx = 16'h4000;
   logic [15:0] ky = 16'h4A86;
   logic [15:0] stub_rx = '0;
   logic [15:0] stub_ry = '0;

   assign bus.i_c_done = stub_done | stray_done;
   assign bus.i_c_busy = stub_act | ext_busy;
   assign bus.i_c_x    = stub_rx;
   assign bus.i_c_y    = stub_ry;

   // Stub CORDIC: done arrives L cycles after the start strobe
   always @(posedge clk) begin
      stub_done <= 1'b0;
      if (bus.o_c_reset) begin
         stub_act <= 1'b0;
         stub_cnt <= 0;
      end else if (bus.o_c_stb) begin
         stub_act <= 1'b1;
         stub_cnt <= 1;
         stub_rx  <= bus.o_c_x ^ kx;
         stub_ry  <= bus.o_c_y ^ ky;
      end else if (stub_act && !stub_never) begin
         if (stub_cnt == L-1) begin
            stub_done <= 1'b1;
            stub_act  <= 1'b0;
         end else begin
            stub_cnt <= stub_cnt + 1;
         end
      end
   end

   // Count response strobes
   always @(negedge clk) begin
      if (|bus.o_rsp_valid) rsp_cnt++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic nclk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_rsp(input int budget, output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!(|bus.o_rsp_valid) && cyc < budget);
   endtask

   task automatic wait_ready(input int budget);
      int cyc = 0;
      while (bus.o_req_ready == '0 && cyc < budget) begin
         @(negedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic do_reset();
      i_reset = 1'b1;
      nclk(2);
      i_reset = 1'b0;
   endtask

   initial begin
      int cyc;
      int cnt0;
      int seen;
      bus.i_req_valid = '0;
      bus.i_req_x     = '0;
      bus.i_req_y     = '0;
      bus.i_req_phase = '0;

      // ---- reset state ----
      nclk(2);
      #1;
      chk("c_reset_in_reset", bus.o_c_reset, 1'b1);
      i_reset = 1'b0;
      #1;
      chk("rst_req_ready", bus.o_req_ready, 4'b0000);
      chk("rst_rsp_valid", bus.o_rsp_valid, 4'b0000);
      chk("rst_c_stb", bus.o_c_stb, 1'b0);
      chk("rst_rsp_err", bus.o_rsp_err, 1'b0);
      chk("rst_rsp_x", bus.o_rsp_x, 16'h0000);
      chk("rst_rsp_y", bus.o_rsp_y, 16'h0000);
      chk("rst_rsp_id", bus.o_rsp_id, 2'd0);
      chk("rst_c_x", bus.o_c_x, 16'h0000);
      chk("rst_c_phase", bus.o_c_phase, 32'h0);
      chk("rst_c_reset_low", bus.o_c_reset, 1'b0);

      // ---- single request on requester 2, 90 degree rotation ----
      nclk(1);
      bus.i_req_x[32 +: 16]     = 16'h4000;
      bus.i_req_y[32 +: 16]     = 16'h0000;
      bus.i_req_phase[64 +: 32] = 32'h4000_0000;
      bus.i_req_valid           = 4'b0100;
      #1;
      chk("single_ready", bus.o_req_ready, 4'b0100);
      nclk(1);
      bus.i_req_valid = '0;
      #1;
      chk("single_stb", bus.o_c_stb, 1'b1);
      chk("single_c_x", bus.o_c_x, 16'h4000);
      chk("single_c_phase", bus.o_c_phase, 32'h4000_0000);
      chk("single_ready_busy", bus.o_req_ready, 4'b0000);
      wait_rsp(100, cyc);
      chk("single_latency", cyc, L+1);
      chk("single_rsp_valid", bus.o_rsp_valid, 4'b0100);
      chk("single_rsp_id", bus.o_rsp_id, 2'd2);
      chk("single_rsp_x", bus.o_rsp_x, 16'h0000);
      chk("single_rsp_y", bus.o_rsp_y, 16'h4A86);
      chk("single_rsp_err", bus.o_rsp_err, 1'b0);
      nclk(1);
      chk("single_rsp_pulse", bus.o_rsp_valid, 4'b0000);
      chk("single_hold_y", bus.o_rsp_y, 16'h4A86);

      // ---- all four requesters held valid, 8 operations ----
      do_reset();
      for (int k = 0; k < NREQ; k++) begin
         bus.i_req_x[16*k +: 16]     = 16'h1111 * 16'(k+1);
         bus.i_req_y[16*k +: 16]     = 16'h0F0F + 16'(k);
         bus.i_req_phase[32*k +: 32] = 32'h1000_0000 * 32'(k+1);
      end
      bus.i_req_valid = 4'b1111;
      #1;
      for (int op = 0; op < 8; op++) begin
         int e;
         e = op % NREQ;
         wait_ready(60);
         chk("rr_ready", bus.o_req_ready, 4'b0001 << e);
         wait_rsp(60, cyc);
         chk("rr_rsp_valid", bus.o_rsp_valid, 4'b0001 << e);
         chk("rr_rsp_id", bus.o_rsp_id, e);
         chk("rr_rsp_x", bus.o_rsp_x, (16'h1111 * 16'(e+1)) ^ kx);
         chk("rr_rsp_y", bus.o_rsp_y, (16'h0F0F + 16'(e)) ^ ky);
      end
      bus.i_req_valid = '0;

      // ---- reset during WAIT, then requester 1 completes ----
      do_reset();
      bus.i_req_valid = 4'b0010;
      #1;
      chk("abort_ready", bus.o_req_ready, 4'b0010);
      nclk(1);
      bus.i_req_valid = '0;
      nclk(10);
      i_reset = 1'b1;
      #1;
      chk("abort_c_reset", bus.o_c_reset, 1'b1);
      cnt0 = rsp_cnt;
      nclk(1);
      i_reset = 1'b0;
      nclk(30);
      #1;
      chk("abort_no_rsp", rsp_cnt, cnt0);
      bus.i_req_valid = 4'b1010;
      #1;
      chk("abort_rr_zero", bus.o_req_ready, 4'b0010);
      nclk(1);
      bus.i_req_valid = '0;
      wait_rsp(60, cyc);
      chk("abort_next_rsp", bus.o_rsp_valid, 4'b0010);
      chk("abort_next_id", bus.o_rsp_id, 2'd1);

      // ---- stray done while idle ----
      nclk(2);
      stray_done = 1'b1;
      nclk(1);
      stray_done = 1'b0;
      #1;
      cnt0 = rsp_cnt;
      nclk(5);
      #1;
      chk("stray_no_rsp", rsp_cnt, cnt0);
      chk("stray_no_stb", bus.o_c_stb, 1'b0);
      bus.i_req_valid = 4'b1001;
      #1;
      chk("stray_still_idle", bus.o_req_ready, 4'b1000);
      nclk(1);
      bus.i_req_valid = '0;
      wait_rsp(60, cyc);
      chk("stray_rsp_id", bus.o_rsp_id, 2'd3);

      // ---- CORDIC busy for 5 cycles after handshake ----
      nclk(1);
      ext_busy        = 1'b1;
      bus.i_req_valid = 4'b0001;
      #1;
      chk("busy_ready", bus.o_req_ready, 4'b0001);
      nclk(1);
      bus.i_req_valid = '0;
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         #1;
         if (bus.o_c_stb) seen++;
         if (i < 4) nclk(1);
      end
      chk("busy_stb_held", seen, 0);
      ext_busy = 1'b0;
      #1;
      chk("busy_stb_go", bus.o_c_stb, 1'b1);
      nclk(1);
      chk("busy_stb_once", bus.o_c_stb, 1'b0);
      wait_rsp(60, cyc);
      chk("busy_rsp_id", bus.o_rsp_id, 2'd0);

`ifdef CORDIC_ARB_TIMEOUT_EN
      // ---- CORDIC never completes ----
      nclk(1);
      stub_never      = 1'b1;
      bus.i_req_valid = 4'b0010;
      nclk(1);
      bus.i_req_valid = '0;
      #1;
      chk("to_stb", bus.o_c_stb, 1'b1);
      cyc = 0;
      do begin
         @(negedge clk);
         #1;
         cyc++;
      end while (!bus.o_c_reset && cyc < 60);
      chk("to_c_reset_time", cyc, 32);
      chk("to_no_rsp_yet", bus.o_rsp_valid, 4'b0000);
      nclk(1);
      chk("to_rsp_valid", bus.o_rsp_valid, 4'b0010);
      chk("to_rsp_err", bus.o_rsp_err, 1'b1);
      chk("to_rsp_x", bus.o_rsp_x, 16'h0000);
      chk("to_rsp_y", bus.o_rsp_y, 16'h0000);
      chk("to_c_reset_pulse", bus.o_c_reset, 1'b0);
      stub_never = 1'b0;
`endif

      nclk(2);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire
